ram_sync_be: RTL and testbench

Single-clock synchronous RAM for the Verilog test designs. It replaces the combinational-write, tri-state-read RAM model with a registered, handshaked memory: a valid/ready request port, per-byte write enables, a fixed configurable read latency with a response-valid strobe, and a hardware clear engine that zeroes the array after reset or on command. It sits behind any test-design master that issues one request per cycle and can always accept read responses.

---
 rtl/ram_sync_be.sv | 159 +++++++++++++++
 tb/tb_ram_sync_be.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_be.sv
// Single-clock synchronous RAM with a valid/ready request port, per-byte write enables,
// a fixed-latency read pipeline and a hardware clear engine that zeroes the array.
module ram_sync_be #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_be,
    input  logic                             clear,
    output logic                             busy,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata
);

    localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic                    started_reg;
    logic [ADDR_WIDTH-1:0]   clr_addr_reg, clr_addr_next;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NBE-1:0]          wr_be;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [READ_LATENCY-1:0]            vld_reg;
    logic [READ_LATENCY*DATA_WIDTH-1:0] data_chain;

    // started_reg marks the first edge after reset release, where the auto-clear may begin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            started_reg  <= 1'b0;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            started_reg  <= 1'b1;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            IDLE: begin
                if (!started_reg) begin
                    if (CLEAR_ON_RESET) begin
                        state_next = CLEAR;
                    end
                end else if (clear) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_addr_reg == {ADDR_WIDTH{1'b1}}) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Requests are only accepted in IDLE, so the clear engine owns the write port alone in CLEAR.
    always_comb begin
        req_ready = (state_reg == IDLE) && started_reg;
        busy      = (state_reg == CLEAR);
        rd_en     = req_valid && req_ready && !req_we;
        if (state_reg == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_reg;
            wr_data = '0;
            wr_be   = '1;
        end else begin
            wr_en   = req_valid && req_ready && req_we;
            wr_addr = req_addr;
            wr_data = req_wdata;
            wr_be   = req_be;
        end
    end

    genvar gi;

    // One narrow array per byte lane keeps each lane a plain write-enabled block RAM.
    generate
        for (gi = 0; gi < NBE; gi++) begin : g_lane
            logic [BYTE_WIDTH-1:0] mem [DEPTH];
            logic [BYTE_WIDTH-1:0] rd_reg;

            always_ff @(posedge clock) begin
                if (wr_en && wr_be[gi]) begin
                    mem[wr_addr] <= wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rd_reg <= '0;
                end else if (rd_en) begin
                    rd_reg <= mem[req_addr];
                end
            end

            assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = rd_reg;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_reg <= '0;
        end else begin
            vld_reg[0] <= rd_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    // Stage 0 is the RAM read register; later stages load only on a valid beat so data holds.
    assign data_chain[0 +: DATA_WIDTH] = rd_word;

    generate
        for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
            logic [DATA_WIDTH-1:0] stage_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stage_reg <= '0;
                end else if (vld_reg[gi-1]) begin
                    stage_reg <= data_chain[(gi-1)*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            assign data_chain[gi*DATA_WIDTH +: DATA_WIDTH] = stage_reg;
        end
    endgenerate

    assign rsp_valid = vld_reg[READ_LATENCY-1];
    assign rsp_rdata = data_chain[(READ_LATENCY-1)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_ram_sync_be.sv
// Bench for ram_sync_be: directed and random requests checked cycle by cycle against a
// word-array model with a due-time response queue.
module tb_ram_sync_be;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int NB  = DW / 8;
    localparam int DEP = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NB-1:0] req_be = '0;
    logic          clear = 1'b0;
    logic          busy;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    ram_sync_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clear(clear), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [DW-1:0] model_mem [DEP];
    rsp_t          pend [$];
    bit            started;
    int            busy_left;
    int            edge_idx = 0;
    logic [DW-1:0] last_rdata;
    logic [DW-1:0] obs_rdata;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_ready();
        return started && (busy_left == 0);
    endfunction

    task automatic start_clear();
        busy_left = DEP;
        for (int i = 0; i < DEP; i++) model_mem[i] = '0;
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = (pend.size() > 0) && (pend[0].due == edge_idx);
        chk("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            chk("rsp_rdata", rsp_rdata, pend[0].data);
            last_rdata = pend[0].data;
            obs_rdata  = rsp_rdata;
            void'(pend.pop_front());
        end else begin
            chk("rsp_hold", rsp_rdata, last_rdata);
        end
        chk("busy", busy, (busy_left > 0));
        chk("req_ready", req_ready, mdl_ready());
    endtask

    task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NB-1:0] be, input logic clr);
        bit   acc;
        rsp_t r;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be; clear = clr;
        acc = v && mdl_ready();
        @(posedge clock);
        edge_idx++;
        if (!started) begin
            started = 1'b1;
            start_clear();
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (acc && we) begin
                for (int i = 0; i < NB; i++)
                    if (be[i]) model_mem[a][i*8 +: 8] = d[i*8 +: 8];
            end else if (acc) begin
                r.data = model_mem[a];
                r.due  = edge_idx + LAT - 1;
                pend.push_back(r);
            end
            if (clr) start_clear();
        end
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        step(1'b1, 1'b1, a, d, be, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b1, 1'b0, a, '0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (busy_left > 0 || pend.size() > 0); i++) idle();
    endtask

    task automatic do_reset();
        req_valid = 1'b0; clear = 1'b0;
        reset = 1'b1;
        #1;
        started = 1'b0; busy_left = 0; last_rdata = '0;
        pend.delete();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEP; i++) model_mem[i] = '0;
        obs_rdata = '0;

        // Power-up reset with automatic clear, then every word reads back as zero.
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (busy === 1'b1) n++;
        end
        chk("auto_clear_len", n, 16);
        for (int i = 0; i < DEP; i++) rd(i[AW-1:0]);
        drain();

        // Byte-lane merge.
        wr(4'h5, 32'hDEADBEEF, 4'b1111);
        wr(4'h5, 32'h00001122, 4'b0011);
        rd(4'h5);
        drain();
        chk("be_merge", obs_rdata, 32'hDEAD1122);

        // Back-to-back reads.
        wr(4'h1, 32'h11, 4'hF);
        wr(4'h2, 32'h22, 4'hF);
        wr(4'h3, 32'h33, 4'hF);
        rd(4'h1); rd(4'h2); rd(4'h3);
        drain();
        chk("b2b_last", obs_rdata, 32'h33);

        // Read accepted alongside a clear pulse returns pre-clear data.
        wr(4'h7, 32'hAB, 4'hF);
        step(1'b1, 1'b0, 4'h7, '0, '0, 1'b1);
        drain();
        chk("read_with_clear", obs_rdata, 32'hAB);
        rd(4'h7);
        drain();
        chk("read_after_clear", obs_rdata, 32'h0);

        // Write with no lanes enabled.
        wr(4'hA, 32'h12345678, 4'hF);
        wr(4'hA, 32'hFFFFFFFF, 4'h0);
        rd(4'hA);
        drain();
        chk("be_zero", obs_rdata, 32'h12345678);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 $urandom_range(0, DEP - 1), $urandom, $urandom_range(0, 15),
                 ($urandom_range(0, 63) == 0));
        end
        drain();

        // Reset part-way through a clear restarts it from address 0.
        wr(4'h3, 32'hCAFEF00D, 4'hF);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 7; i++) idle();
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (busy === 1'b1) n++;
        end
        chk("restart_clear_len", n, 16);
        rd(4'h3);
        drain();
        chk("restart_cleared", obs_rdata, 32'h0);
        chk("pend_empty", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
